fft_frame_sequencer: RTL
========================

Name: fft_frame_sequencer

Overview:
Controller that sequences one FFT frame from the sample block RAM into the streaming FFT core. On start it issues the FFT config word, streams N_FFT samples from RAM with correct tlast, absorbs RAM read latency under input-side backpressure, then waits for the FFT output frame to drain before reporting done. It replaces the free-running counter and tied-off config/tlast driving that feed the FFT today, and sits between signal memory and the FFT core ahead of harmonic_product_spectrum.

Parameters:
N_FFT, 8192, samples per frame (power of 2)
ADDR_W, 13, sample RAM address width (2^ADDR_W >= N_FFT)
SAMPLE_W, 12, sample width from RAM
SCALE_SCH, 7'b0000101, config bits [7:1]; forward frame gives cfg 8'h0B

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to process a frame; ignored while busy
base_addr  in  ADDR_W  first sample address, sampled on accepted start
fwd_inv  in  1  1 = forward FFT, sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of frame
err  out  1  sticky error; set by fft_event, cleared on accepted start
fft_event  in  1  OR of FFT tlast_unexpected/tlast_missing events
ram_en  out  1  RAM read enable
ram_addr  out  ADDR_W  RAM read address
ram_data  in  SAMPLE_W  RAM read data, valid 1 cycle after ram_en
cfg_tdata  out  8  {SCALE_SCH, fwd_inv}
cfg_tvalid  out  1  config valid
cfg_tready  in  1  config ready
s_tdata  out  32  {16'b0 imag, zero-extended sample real}
s_tvalid  out  1  data valid
s_tready  in  1  data ready
s_tlast  out  1  high on sample N_FFT-1
m_tvalid  in  1  FFT output valid (monitored only)
m_tready  in  1  FFT output ready (monitored only)
m_tlast  in  1  FFT output last (monitored only)
frame_count  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset: all outputs 0, state IDLE, skid buffer empty, frame_count 0; asserting reset mid-frame aborts it with no done pulse.
- States: IDLE -> CFG on start (busy=1 next cycle, err cleared, base_addr/fwd_inv latched). CFG: cfg_tvalid=1 until cfg_tvalid&cfg_tready, then STREAM. STREAM: until N_FFT data handshakes, then DRAIN. DRAIN: wait for m_tvalid&m_tready&m_tlast, then DONE. DONE: done=1, frame_count++, -> IDLE (busy 0 next cycle).
- Reads: prefetch allowed from CFG onward. 2-entry skid FIFO; ram_en asserted only when occupancy + reads in flight < 2 and issued count < N_FFT. ram_addr = base_addr + issued count, mod 2^ADDR_W (wraps past top of RAM).
- s_tvalid only in STREAM with FIFO non-empty; no sample leaves before config accepted. Data/tlast held stable while s_tvalid & !s_tready. Sample popped on handshake; same-cycle push and pop allowed.
- Zero-bubble: with s_tready held 1, one sample per cycle after first; frame streaming N_FFT+1 cycles after entering STREAM worst case.
- tlast set exactly on the N_FFT-th accepted sample; never on any other.
- start while busy ignored (no latch). start in DONE cycle ignored.
- fft_event sets err in any state; err holds until next accepted start (start and fft_event same cycle: err=1).
- m_tlast seen outside DRAIN ignored.

Decomposition:
- Package fft_seq_pkg: state enum (IDLE, CFG, STREAM, DRAIN, DONE), N_FFT/ADDR_W defaults, cfg word packing function.
- One sub-module: fft_seq_skid (2-entry valid/ready FIFO, SAMPLE_W+1 wide carrying tlast).

Test Plan:
- N_FFT=16, base 0, s_tready=1, RAM data=addr: cfg 8'h0B once, samples 0..15 consecutive, tlast only on 15, done after m_tlast, frame_count=1.
- s_tready toggled random 50%: sequence 0..15 intact, no drop/dup, s_tdata stable while stalled, exactly 16 handshakes.
- base_addr=2^ADDR_W-4, N_FFT=16: ram_addr wraps ...FFC..FFF,0..B; fwd_inv=0 gives cfg 8'h0A.
- cfg_tready held 0 for 10 cycles: s_tvalid stays 0, at most 2 reads issued; streaming begins after cfg handshake.
- start pulsed during STREAM and on DONE: ignored, frame_count increments by 1 only.
- reset asserted mid-STREAM: all outputs 0 immediately, no done; new start then runs a clean full frame; fft_event pulse -> err=1 until next start.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// rtl/fft_seq_pkg.sv - shared types, defaults and config packing for the FFT frame sequencer
package fft_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG    = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

  localparam int N_FFT_DEF    = 8192;
  localparam int ADDR_W_DEF   = 13;
  localparam int SAMPLE_W_DEF = 12;
  localparam logic [6:0] SCALE_SCH_DEF = 7'b0000101;
  localparam int CFG_W = 8;

  function automatic logic [CFG_W-1:0] pack_cfg(input logic [6:0] scale_sch, input logic fwd);
    return {scale_sch, fwd};
  endfunction

endpackage

// File: rtl/fft_seq_skid.sv
// rtl/fft_seq_skid.sv - two-entry valid/ready FIFO holding prefetched samples and their tlast tag
module fft_seq_skid #(
  parameter int W = 13
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic [W-1:0] wr_data,
  input  logic         wr_en,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  input  logic         rd_en,
  output logic [1:0]   level
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         pop;

  assign rd_valid = (count != 2'd0);
  assign pop      = rd_en && rd_valid;
  assign rd_data  = mem[rd_ptr];
  assign level    = count;

  // Writer never overfills: the controller budgets reads against level plus in-flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, wr_en} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - sequences one FFT frame: config word, N_FFT samples from RAM, output drain
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int N_FFT    = N_FFT_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter logic [6:0] SCALE_SCH = SCALE_SCH_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                fwd_inv,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                fft_event,
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [SAMPLE_W-1:0] ram_data,
  output logic [7:0]          cfg_tdata,
  output logic                cfg_tvalid,
  input  logic                cfg_tready,
  output logic [31:0]         s_tdata,
  output logic                s_tvalid,
  input  logic                s_tready,
  output logic                s_tlast,
  input  logic                m_tvalid,
  input  logic                m_tready,
  input  logic                m_tlast,
  output logic [15:0]         frame_count
);

  localparam int CNT_W = $clog2(N_FFT) + 1;
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_FFT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FFT - 1);

  seq_state_t          state;
  seq_state_t          state_next;
  logic [ADDR_W-1:0]   base_q;
  logic [7:0]          cfg_q;
  logic [CNT_W-1:0]    issued;
  logic                inflight;
  logic                inflight_last;
  logic                err_q;
  logic [15:0]         frame_q;

  logic                start_ok;
  logic                fetch_phase;
  logic                pop;
  logic [2:0]          occ_after;
  logic [SAMPLE_W:0]   head;
  logic                head_valid;
  logic [1:0]          level;
  logic [SAMPLE_W-1:0] head_sample;
  logic                head_last;

  assign start_ok    = (state == IDLE) && start;
  assign fetch_phase = (state == CFG) || (state == STREAM);

  assign head_sample = head[SAMPLE_W-1:0];
  assign head_last   = head[SAMPLE_W];

  assign s_tvalid = (state == STREAM) && head_valid;
  assign pop      = s_tvalid && s_tready;
  assign s_tdata  = {16'b0, 16'(head_sample)};
  assign s_tlast  = s_tvalid && head_last;

  // Counting this cycle's pop lets a new read issue while the FIFO drains, keeping one sample per cycle.
  assign occ_after = 3'(level) + 3'(inflight) - 3'(pop);
  assign ram_en    = fetch_phase && (issued < N_CNT) && (occ_after < 3'd2);
  assign ram_addr  = base_q + ADDR_W'(issued);

  assign cfg_tvalid  = (state == CFG);
  assign cfg_tdata   = cfg_q;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign err         = err_q;
  assign frame_count = frame_q;

  fft_seq_skid #(
    .W(SAMPLE_W + 1)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .flush    (start_ok),
    .wr_data  ({inflight_last, ram_data}),
    .wr_en    (inflight),
    .rd_data  (head),
    .rd_valid (head_valid),
    .rd_en    (pop),
    .level    (level)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CFG;
      CFG:     if (cfg_tready) state_next = STREAM;
      STREAM:  if (pop && head_last) state_next = DRAIN;
      DRAIN:   if (m_tvalid && m_tready && m_tlast) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      base_q        <= '0;
      cfg_q         <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      err_q         <= 1'b0;
      frame_q       <= '0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        base_q <= base_addr;
        cfg_q  <= pack_cfg(SCALE_SCH, fwd_inv);
        issued <= '0;
      end else if (ram_en) begin
        issued <= issued + CNT_W'(1);
      end
      // The tlast tag travels with the read of the final index so it lands on exactly that sample.
      inflight      <= ram_en;
      inflight_last <= ram_en && (issued == LAST_IDX);
      if (fft_event) begin
        err_q <= 1'b1;
      end else if (start_ok) begin
        err_q <= 1'b0;
      end
      if (state == DONE) begin
        frame_q <= frame_q + 16'd1;
      end
    end
  end

endmodule
